// File: rtl/maze_path_stack.sv
// Location stack for the maze solver's DFS path, with a bottom-to-top replay engine.
// Optional PATH_STATS_EN adds max_depth (high-water mark) and backtracks (pop count) outputs.
module maze_path_stack #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int W     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic          rd_top,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic          full,
    output logic          ovf,
    output logic          unf,
    input  logic          replay_start,
    output logic          replay_valid,
    input  logic          replay_ready,
    output logic [W-1:0]  replay_loc,
    output logic          replay_done,
`ifdef PATH_STATS_EN
    output logic [AW:0]   max_depth,
    output logic [15:0]   backtracks,
`endif
    output logic          busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [AW:0]   sp_q, sp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [W-1:0]  dout_q, dout_d;
    logic [W-1:0]  replay_loc_q, replay_loc_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          ops_en;
    logic          clr_en;
    logic [W-1:0]  mem [DEPTH];

    assign empty = (sp_q == '0);
    assign full  = (sp_q == DEPTH_P);

    // Replay start wins over stack ops and clear; nothing touches the stack mid-replay.
    assign ops_en = (state_q == S_IDLE) && !replay_start;
    assign clr_en = clr && (state_q != S_RUN) && !((state_q == S_IDLE) && replay_start);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sp_q         <= '0;
            rp_q         <= '0;
            dout_q       <= '0;
            replay_loc_q <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sp_q         <= sp_d;
            rp_q         <= rp_d;
            dout_q       <= dout_d;
            replay_loc_q <= replay_loc_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= din;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (replay_start) begin
                    state_d = empty ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (replay_ready && (rp_q == sp_q[AW-1:0] - AW'(1))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q == S_RUN);
        replay_valid = (state_q == S_RUN);
        replay_done  = (state_q == S_DONE);
    end

    // Push+pop on a non-empty stack overwrites the top; on an empty stack it is a plain push.
    always_comb begin
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        wr_en   = 1'b0;
        wr_addr = sp_q[AW-1:0];
        dout_d  = dout_q;
        rd_addr = '0;
        if (clr_en) begin
            sp_d  = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else if (ops_en) begin
            if (push && pop && !empty) begin
                wr_en   = 1'b1;
                wr_addr = sp_q[AW-1:0] - AW'(1);
            end else if (push && !full) begin
                wr_en = 1'b1;
                sp_d  = sp_q + (AW+1)'(1);
            end else if (push && !pop) begin
                ovf_d = 1'b1;
            end else if (pop && !empty) begin
                sp_d = sp_q - (AW+1)'(1);
            end else if (pop && !push) begin
                unf_d = 1'b1;
            end
        end
        if (rd_top && (state_q == S_IDLE)) begin
            rd_addr = sp_d[AW-1:0] - AW'(1);
            if (sp_d == '0) begin
                dout_d = '0;
            end else if (wr_en && (wr_addr == rd_addr)) begin
                dout_d = din;
            end else begin
                dout_d = mem[rd_addr];
            end
        end
    end

    // The next entry is fetched on acceptance so the stream has no bubbles.
    always_comb begin
        rp_d         = rp_q;
        replay_loc_d = replay_loc_q;
        if ((state_q == S_IDLE) && replay_start && !empty) begin
            rp_d         = '0;
            replay_loc_d = mem[0];
        end else if ((state_q == S_RUN) && replay_ready &&
                     (rp_q != sp_q[AW-1:0] - AW'(1))) begin
            rp_d         = rp_q + AW'(1);
            replay_loc_d = mem[rp_q + AW'(1)];
        end
    end

    assign dout       = dout_q;
    assign replay_loc = replay_loc_q;
    assign ovf        = ovf_q;
    assign unf        = unf_q;

`ifdef PATH_STATS_EN
    logic [AW:0] max_depth_q, max_depth_d;
    logic [15:0] backtracks_q, backtracks_d;

    // A successful pop is the only non-clear event that lowers the pointer.
    always_comb begin
        max_depth_d  = max_depth_q;
        backtracks_d = backtracks_q;
        if (clr_en) begin
            max_depth_d  = '0;
            backtracks_d = '0;
        end else begin
            if (sp_d > max_depth_q) begin
                max_depth_d = sp_d;
            end
            if ((sp_d < sp_q) && (backtracks_q != 16'hFFFF)) begin
                backtracks_d = backtracks_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_depth_q  <= '0;
            backtracks_q <= '0;
        end else begin
            max_depth_q  <= max_depth_d;
            backtracks_q <= backtracks_d;
        end
    end

    assign max_depth  = max_depth_d == max_depth_d ? max_depth_q : max_depth_q;
    assign backtracks = backtracks_q;
`endif

endmodule

// File: tb/tb_maze_path_stack.sv
// Directed bench for maze_path_stack: table-driven stack vectors plus replay/reset sequences.
// Define PATH_STATS_EN to also exercise the statistics outputs.
module tb_maze_path_stack;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       push;
    logic       pop;
    logic       rd_top;
    logic [7:0] din;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       unf;
    logic       replay_start;
    logic       replay_valid;
    logic       replay_ready;
    logic [7:0] replay_loc;
    logic       replay_done;
    logic       busy;
`ifdef PATH_STATS_EN
    logic [8:0]  max_depth;
    logic [15:0] backtracks;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic       push;
        logic       pop;
        logic       rd_top;
        logic       clr;
        logic [7:0] din;
        logic       exp_empty;
        logic       exp_full;
        logic       exp_ovf;
        logic       exp_unf;
        logic       chk_dout;
        logic [7:0] exp_dout;
        string      name;
    } vec_t;

    maze_path_stack dut (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .push         (push),
        .pop          (pop),
        .rd_top       (rd_top),
        .din          (din),
        .dout         (dout),
        .empty        (empty),
        .full         (full),
        .ovf          (ovf),
        .unf          (unf),
        .replay_start (replay_start),
        .replay_valid (replay_valid),
        .replay_ready (replay_ready),
        .replay_loc   (replay_loc),
        .replay_done  (replay_done),
`ifdef PATH_STATS_EN
        .max_depth    (max_depth),
        .backtracks   (backtracks),
`endif
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual running, required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
        end
    endtask

    // Drives one cycle of stack inputs, then leaves the bench 1 time unit after the edge.
    task automatic applyStimulus(input logic p_push, input logic p_pop, input logic p_rd,
                                 input logic p_clr, input logic [7:0] p_din);
        push   = p_push;
        pop    = p_pop;
        rd_top = p_rd;
        clr    = p_clr;
        din    = p_din;
        @(posedge clk);
        #1;
        push   = 1'b0;
        pop    = 1'b0;
        rd_top = 1'b0;
        clr    = 1'b0;
        din    = 8'h00;
    endtask

    task automatic stepIdle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t       vecs[16];
        logic       pat[5];
        logic [7:0] exp_path[4];
        logic [7:0] got[8];
        int         n_got;
        int         k;
        int         done_cnt;
        logic       done_seen;
        logic       valid_at_done;

        rst          = 1'b1;
        clr          = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        rd_top       = 1'b0;
        din          = 8'h00;
        replay_start = 1'b0;
        replay_ready = 1'b0;

        //             push pop  rd   clr  din    emp  full ovf  unf  chk  dout
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,"push00"};
        vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,8'h01, 1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,"push01"};
        vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,8'h11, 1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,"push11"};
        vecs[3]  = '{1'b0,1'b0,1'b1,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b1,8'h11,"rd_top3"};
        vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b1,8'h11,"pop_a"};
        vecs[5]  = '{1'b0,1'b0,1'b1,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b1,8'h01,"rd_after_pop"};
        vecs[6]  = '{1'b0,1'b1,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,"pop_b"};
        vecs[7]  = '{1'b0,1'b1,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,"pop_c"};
        vecs[8]  = '{1'b0,1'b1,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b1,1'b0,8'h00,"pop_empty"};
        vecs[9]  = '{1'b0,1'b0,1'b1,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b1,1'b1,8'h00,"rd_empty"};
        vecs[10] = '{1'b1,1'b1,1'b0,1'b0,8'h77, 1'b0,1'b0,1'b0,1'b1,1'b0,8'h00,"pushpop_empty"};
        vecs[11] = '{1'b0,1'b0,1'b1,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b1,1'b1,8'h77,"rd_77"};
        vecs[12] = '{1'b1,1'b0,1'b1,1'b0,8'h22, 1'b0,1'b0,1'b0,1'b1,1'b1,8'h22,"push_rd"};
        vecs[13] = '{1'b0,1'b1,1'b1,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b1,1'b1,8'h77,"pop_rd"};
        vecs[14] = '{1'b0,1'b0,1'b0,1'b1,8'h00, 1'b1,1'b0,1'b0,1'b0,1'b1,8'h77,"clr"};
        vecs[15] = '{1'b0,1'b1,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b1,1'b0,8'h00,"pop_after_clr"};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.dout",  16'(dout), 16'h00);
        checkOutput("rst.empty", 16'(empty), 16'h1);
        checkOutput("rst.full",  16'(full), 16'h0);
        checkOutput("rst.ovf",   16'(ovf), 16'h0);
        checkOutput("rst.unf",   16'(unf), 16'h0);
        checkOutput("rst.valid", 16'(replay_valid), 16'h0);
        checkOutput("rst.done",  16'(replay_done), 16'h0);
        checkOutput("rst.busy",  16'(busy), 16'h0);
        checkOutput("rst.loc",   16'(replay_loc), 16'h00);
        rst = 1'b0;
        stepIdle();

        $display("[TB] stack vector table");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].push, vecs[i].pop, vecs[i].rd_top, vecs[i].clr, vecs[i].din);
            checkOutput($sformatf("%s.empty", vecs[i].name), 16'(empty), 16'(vecs[i].exp_empty));
            checkOutput($sformatf("%s.full", vecs[i].name),  16'(full),  16'(vecs[i].exp_full));
            checkOutput($sformatf("%s.ovf", vecs[i].name),   16'(ovf),   16'(vecs[i].exp_ovf));
            checkOutput($sformatf("%s.unf", vecs[i].name),   16'(unf),   16'(vecs[i].exp_unf));
            if (vecs[i].chk_dout) begin
                checkOutput($sformatf("%s.dout", vecs[i].name), 16'(dout), 16'(vecs[i].exp_dout));
            end
        end

        $display("[TB] fill to full");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
            if (i == 254) begin
                checkOutput("fill.not_full_at_255", 16'(full), 16'h0);
            end
        end
        checkOutput("fill.full",  16'(full), 16'h1);
        checkOutput("fill.empty", 16'(empty), 16'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'hAA);
        checkOutput("full_push.ovf",  16'(ovf), 16'h1);
        checkOutput("full_push.full", 16'(full), 16'h1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("full_push.top", 16'(dout), 16'hFF);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
        checkOutput("full_swap.full", 16'(full), 16'h1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("full_swap.top", 16'(dout), 16'h55);
        checkOutput("full_swap.ovf", 16'(ovf), 16'h1);

        $display("[TB] replay with toggling ready");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        exp_path = '{8'h00, 8'h10, 8'h20, 8'hFF};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, exp_path[i]);
        end
        replay_start = 1'b1;
        replay_ready = 1'b0;
        stepIdle();
        replay_start = 1'b0;
        checkOutput("replay.first_valid", 16'(replay_valid), 16'h1);
        checkOutput("replay.busy",        16'(busy), 16'h1);
        checkOutput("replay.first_loc",   16'(replay_loc), 16'h00);
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        n_got = 0;
        k = 0;
        done_seen = 1'b0;
        valid_at_done = 1'b1;
        for (int cyc = 0; cyc < 20 && !done_seen; cyc++) begin
            replay_ready = (k < 5) ? pat[k] : 1'b1;
            k++;
            if (replay_valid && replay_ready && n_got < 8) begin
                got[n_got] = replay_loc;
                n_got++;
            end
            stepIdle();
            if (replay_done) begin
                done_seen = 1'b1;
                valid_at_done = replay_valid;
            end
        end
        replay_ready = 1'b0;
        checkOutput("replay.done_seen", 16'(done_seen), 16'h1);
        checkOutput("replay.count", 16'(n_got), 16'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("replay.loc%0d", i), 16'(got[i]), 16'(exp_path[i]));
        end
        checkOutput("replay.valid_at_done", 16'(valid_at_done), 16'h0);
        checkOutput("replay.busy_at_done", 16'(busy), 16'h0);
        stepIdle();
        checkOutput("replay.done_one_cycle", 16'(replay_done), 16'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("replay.top_kept", 16'(dout), 16'hFF);
        checkOutput("replay.not_empty", 16'(empty), 16'h0);

        $display("[TB] replay of empty stack");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        replay_start = 1'b1;
        stepIdle();
        replay_start = 1'b0;
        checkOutput("empty_replay.valid", 16'(replay_valid), 16'h0);
        checkOutput("empty_replay.done",  16'(replay_done), 16'h1);
        stepIdle();
        checkOutput("empty_replay.done_low", 16'(replay_done), 16'h0);

`ifdef PATH_STATS_EN
        $display("[TB] path statistics");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h09);
        checkOutput("stats.max_depth",  16'(max_depth), 16'd5);
        checkOutput("stats.backtracks", backtracks, 16'd3);
`endif

        $display("[TB] reset during replay");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'hA0 + i));
        replay_start = 1'b1;
        stepIdle();
        replay_start = 1'b0;
        replay_ready = 1'b1;
        stepIdle();
        stepIdle();
        checkOutput("rst_run.loc_before", 16'(replay_loc), 16'hA2);
        #2;
        rst = 1'b1;
        #1;
        replay_ready = 1'b0;
        checkOutput("rst_run.busy",  16'(busy), 16'h0);
        checkOutput("rst_run.valid", 16'(replay_valid), 16'h0);
        checkOutput("rst_run.empty", 16'(empty), 16'h1);
        checkOutput("rst_run.done",  16'(replay_done), 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            stepIdle();
            if (replay_done) done_cnt++;
        end
        checkOutput("rst_run.no_done", 16'(done_cnt), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/maze_path_stack.md
Name: maze_path_stack

Overview:
- Location stack serving the maze-solver controller's push / pop / read-top requests.
- Holds the 8-bit cell coordinates of the current DFS path and reports empty/full status back to the controller.
- After a solve completes, a replay engine drains the stored path bottom-to-top (start cell first) over a valid/ready stream for the display/output stage.
- Sits between the solver controller and the maze datapath's location register.

Parameters:
- DEPTH, 256: number of stack entries (one per maze cell).
- AW, 8: pointer width; must satisfy 2^AW >= DEPTH.
- W, 8: entry width, the cell coordinate {row[3:0], col[3:0]}.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous clear of stack pointer and sticky flags.
- push  in  1  store din on top of stack.
- pop  in  1  discard top entry.
- rd_top  in  1  request a registered read of the current top entry.
- din  in  W  location to push.
- dout  out  W  top-entry read data, valid the cycle after rd_top.
- empty  out  1  sp == 0.
- full  out  1  sp == DEPTH.
- ovf  out  1  sticky: push attempted while full.
- unf  out  1  sticky: pop attempted while empty.
- replay_start  in  1  begin path replay.
- replay_valid  out  1  replay_loc holds a valid entry.
- replay_ready  in  1  consumer accepts replay_loc.
- replay_loc  out  W  path entry, index 0 first.
- replay_done  out  1  one-cycle pulse at end of replay.
- busy  out  1  replay in progress.

Behaviour:
- Reset state (rst high):
  - sp = 0, dout = 0, ovf = 0, unf = 0.
  - FSM in IDLE, replay_valid = 0, replay_done = 0, busy = 0, replay_loc = 0.
  - empty = 1, full = 0.
  - Storage contents are not reset.
- Stack operations, evaluated in IDLE only, on the posedge:
  - push and not full: mem[sp] <= din; sp <= sp+1.
  - pop and not empty: sp <= sp-1.
  - push and pop together, not empty: overwrite top, mem[sp-1] <= din; sp unchanged.
  - push and pop together, empty: treated as a plain push; unf is not set.
  - push while full, with no pop: ignored; ovf <= 1.
  - pop while empty, with no push: ignored; unf <= 1.
- Top read:
  - rd_top: dout <= mem[sp_next-1], where sp_next is the pointer after any same-cycle push/pop. A read issued with a pop therefore returns the new top.
  - rd_top while empty: dout <= 0.
  - dout holds its value until the next rd_top.
  - The controller's pop-then-read sequence (pop cycle, then read cycle) returns the new top one cycle after the read cycle.
- clr: sp <= 0, ovf <= 0, unf <= 0. Has priority over push/pop in the same cycle. Ignored while busy.
- empty and full are combinational from sp.
- Replay FSM: IDLE -> RUN -> DONE -> IDLE.
  - IDLE:
    - replay_start with sp > 0: rp <= 0, go to RUN.
    - replay_start with sp == 0: go to DONE.
    - replay_start has priority over push/pop in the same cycle; those ops are dropped.
  - RUN:
    - busy = 1, replay_valid = 1, replay_loc = mem[rp] (registered, stable while not accepted).
    - Handshake valid & ready: if rp == sp-1, go to DONE; else rp <= rp+1 and load the next entry, with no bubble.
    - push, pop, rd_top and clr are ignored (no flag updates).
    - sp is unchanged by replay; the path remains stored for re-replay.
  - DONE: replay_done = 1 for exactly one cycle, replay_valid = 0, then IDLE.
- Timing:
  - First replay_valid appears the cycle after replay_start.
  - Throughput is one entry per cycle with ready held high.
- Reset mid-replay: immediate return to IDLE with sp = 0; no replay_done pulse.

Optional Feature:
- Macro: PATH_STATS_EN.
- Defined:
  - Adds output max_depth [AW:0]: the high-water mark of sp since reset/clr, updated the same cycle sp increases.
  - Adds output backtracks [15:0]: counts successful pops, saturating at 16'hFFFF.
  - Both outputs reset to 0 and are cleared by clr.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Push 8'h00, 8'h01, 8'h11, then rd_top -> dout = 8'h11 the next cycle; empty = 0; sp = 3.
- From that state, pop then rd_top in the next cycle -> dout = 8'h01; pop ×2 -> empty = 1; further pop -> unf = 1, sp stays 0.
- Fill all 256 entries (din = index) -> full = 1; push 8'hAA -> ovf = 1, mem[255] still 8'hFF; simultaneous push 8'h55 + pop -> top = 8'h55, full stays 1.
- Push 8'h00, 8'h10, 8'h20, 8'hFF, then replay_start with ready toggling 1,0,1,1,1 -> replay_loc sequence 00, 10, 20, FF with no duplicates or drops; replay_done pulse after the FF acceptance; sp still 4.
- replay_start with empty stack -> no replay_valid; replay_done pulse on the following cycle.
- Assert rst during RUN after 2 acceptances -> busy = 0, replay_valid = 0, empty = 1 immediately; no replay_done. With PATH_STATS_EN: push 5, pop 3, push 1 -> max_depth = 5, backtracks = 3.
